cordic_rotate_iter: RTL and testbench
=====================================

# cordic_rotate_iter

Iterative CORDIC rotation-mode engine: converts a polar pair (signed magnitude, normalised angle) to Cartesian x = mag·cos θ, y = mag·sin θ. It is the inverse of the vectoring CORDIC used by the Sobel edge-detect path, which produces magnitude and angle. It reuses the same 20-bit angle normalisation and arctan table. It performs one micro-rotation per clock under a valid/ready handshake and feeds gradient-overlay and direction-visualisation logic.

## Interface
- DW, 16, width of magnitude input and x/y outputs (signed)
- T_IR_NUM, 15, micro-rotations per operation, legal range 1..18
- DW_NOR, 20, angle width; 2^20 = 360°; fixed, do not change
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low)
- din_valid  in  1  input pair present
- din_ready  out  1  engine can accept; registered
- din_mag  in  DW  signed magnitude; caller guarantees |din_mag| ≤ 2^(DW-2)-1
- din_angle  in  DW_NOR  unsigned angle, 0..2^20-1
- dout_valid  out  1  result present
- dout_ready  in  1  downstream accepts result
- dout_x  out  DW  signed mag·cos θ
- dout_y  out  DW  signed mag·sin θ

## Operation
- Internal width IW = DW+3 for x, y, with 2 fractional guard bits. z is a signed DW_NOR register.
- Arctan LUT, value round(atan(2^-i)/(2π)·2^20), for i = 0..17: 0x20000, 0x12E40, 0x09FB4, 0x05111, 0x028B1, 0x0145D, 0x00A2F, 0x00518, 0x0028C, 0x00146, 0x000A3, 0x00051, 0x00029, 0x00014, 0x0000A, 0x00005, 0x00003, 0x00001.
- Gain pre-compensation: s = (din_mag · 39797) >>> 14, arithmetic. 39797 = round(2^16/K), K = 1.646760. Result is in IW bits, scaled ×4.
- Quadrant pre-rotation by q = din_angle[19:18]:
  - q = 0 or 3: x0 = s, z0 = din_angle as signed.
  - q = 1 or 2: x0 = −s, z0 = din_angle with bit 19 inverted, as signed.
  - y0 = 0 in both cases. This keeps z0 in [−2^18, 2^18).
- Iteration i = 0..T_IR_NUM−1, with d = +1 if z ≥ 0, else −1:
  - x ← x − d·(y >>> i)
  - y ← y + d·(x >>> i)
  - z ← z − d·LUT[i]
  - All updates use pre-iteration values; shifts are arithmetic (sign-filling).
- Output: dout_x = x >>> 2 and dout_y = y >>> 2, truncated to DW bits. No rounding.
- FSM states:
  - IDLE: din_ready = 1. On din_valid & din_ready, register x0, y0, z0, clear counter, go to CALC.
  - CALC: one iteration per cycle, counter increments. After the iteration with counter = T_IR_NUM−1, load dout_x/dout_y and go to DONE.
  - DONE: dout_valid = 1, outputs held stable. On dout_ready, go to IDLE.
- din_ready is 0 in CALC and DONE. There is no input buffering and no back-to-back overlap.
- din_valid while not ready is ignored and is not captured later.
- Inputs are sampled only on the accept edge. Later changes to din_mag/din_angle do not affect an operation in progress.

## Timing
- Reset values, with rst_n low at a posedge: state IDLE, din_ready 0, dout_valid 0, dout_x 0, dout_y 0, counter 0, x/y/z 0.
- din_ready rises on the first posedge with rst_n high.
- Accept edge is E. CALC occupies edges E+1..E+T_IR_NUM. dout_valid = 1 after edge E+T_IR_NUM; default latency is 15 cycles.
- Result is consumed on the first edge with dout_valid & dout_ready. dout_valid falls and din_ready rises after that same edge.
- Minimum period between accepts is T_IR_NUM+2 cycles when dout_ready is held high.
- dout_x/dout_y update only on entry to DONE and are held through IDLE until the next result.
- Reset asserted in any state, including mid-CALC or DONE, aborts the operation and restores reset values on that edge. No partial result is ever presented.
- Accuracy at T_IR_NUM = 15: |error| ≤ 3 LSB on each output for legal inputs.

## Test plan
- Cardinal angles, mag = 10000:
  - angle 0x00000 → (10000, 0)
  - angle 0x40000 → (0, 10000)
  - angle 0x80000 → (−10000, 0)
  - angle 0xC0000 → (0, −10000)
  - All within ±3 LSB; latency exactly 15 cycles from accept to dout_valid.
- Diagonals, mag = 10000:
  - 0x20000 → (7071, 7071)
  - 0x60000 → (−7071, 7071)
  - 0xE0000 → (7071, −7071)
  - All ±3 LSB.
- Negative and extreme magnitudes:
  - mag = −8000, angle 0x80000 → (8000, 0).
  - mag = 16383, angle 0x3FFFF → x ≈ 0, y ≈ 16383. No wrap.
- Backpressure: hold dout_ready = 0 for 5 cycles in DONE with din_valid = 1 → dout_x/dout_y stable, din_ready = 0, no second capture. Release → dout_valid falls on the next edge.
- Reset mid-CALC: assert rst_n low for 1 cycle at iteration 7 → all outputs 0 next cycle, din_ready 1 one cycle after release. A fresh operation then returns the correct result.
- Random sweep: 1000 random (mag, angle) pairs with dout_ready randomly toggled → every result matches a floating-point model within ±3 LSB. Exactly one dout_valid/dout_ready transfer per accepted input, in order.

Source files
------------

// File: rtl/cordic_rotate_iter.sv
// Iterative CORDIC rotation engine: (signed magnitude, 20-bit angle) -> (x, y),
// one micro-rotation per clock under a valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   din_valid/din_ready  input handshake (din_ready registered)
//   din_mag              signed magnitude, |din_mag| <= 2^(DW-2)-1
//   din_angle            unsigned angle, 2^DW_NOR = 360 degrees
//   dout_valid/dout_ready output handshake
//   dout_x, dout_y       signed mag*cos(theta), mag*sin(theta)
module cordic_rotate_iter #(
    parameter int unsigned DW       = 16,
    parameter int unsigned T_IR_NUM = 15,
    parameter int unsigned DW_NOR   = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic signed [DW-1:0]     din_mag,
    input  logic        [DW_NOR-1:0] din_angle,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic signed [DW-1:0]     dout_x,
    output logic signed [DW-1:0]     dout_y
);

    localparam int unsigned IW      = DW + 3;   // 2 fractional guard bits + headroom
    localparam int unsigned CW      = 5;        // holds iteration index up to 17
    localparam int unsigned PW      = DW + 18;  // full gain-product width
    localparam int unsigned GAIN_SH = 14;
    localparam logic signed [PW-1:0] GAIN = PW'(39797);  // round(2^16 / K)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic        [CW-1:0]      cnt_q, cnt_d;
    logic signed [IW-1:0]      x_q, x_d, y_q, y_d;
    logic signed [DW_NOR-1:0]  z_q, z_d;
    logic                      din_ready_d, dout_valid_d;
    logic signed [DW-1:0]      dout_x_d, dout_y_d;

    logic signed [PW-1:0]      prod;
    logic signed [IW-1:0]      s_val;
    logic signed [IW-1:0]      x_sh, y_sh, x_it, y_it;
    logic signed [DW_NOR-1:0]  z_it, lut_val;
    logic                      swap_half;

    // atan(2^-i) in units of 2^-20 turns
    function automatic logic signed [DW_NOR-1:0] atan_lut(input logic [CW-1:0] i);
        case (i)
            5'd0:    atan_lut = DW_NOR'(20'h20000);
            5'd1:    atan_lut = DW_NOR'(20'h12E40);
            5'd2:    atan_lut = DW_NOR'(20'h09FB4);
            5'd3:    atan_lut = DW_NOR'(20'h05111);
            5'd4:    atan_lut = DW_NOR'(20'h028B1);
            5'd5:    atan_lut = DW_NOR'(20'h0145D);
            5'd6:    atan_lut = DW_NOR'(20'h00A2F);
            5'd7:    atan_lut = DW_NOR'(20'h00518);
            5'd8:    atan_lut = DW_NOR'(20'h0028C);
            5'd9:    atan_lut = DW_NOR'(20'h00146);
            5'd10:   atan_lut = DW_NOR'(20'h000A3);
            5'd11:   atan_lut = DW_NOR'(20'h00051);
            5'd12:   atan_lut = DW_NOR'(20'h00029);
            5'd13:   atan_lut = DW_NOR'(20'h00014);
            5'd14:   atan_lut = DW_NOR'(20'h0000A);
            5'd15:   atan_lut = DW_NOR'(20'h00005);
            5'd16:   atan_lut = DW_NOR'(20'h00003);
            5'd17:   atan_lut = DW_NOR'(20'h00001);
            default: atan_lut = '0;
        endcase
    endfunction

    // Gain pre-compensation; result is magnitude/K scaled by 4
    always_comb begin
        prod      = PW'(din_mag) * GAIN;
        s_val     = IW'(prod >>> GAIN_SH);
        swap_half = din_angle[DW_NOR-1] ^ din_angle[DW_NOR-2];  // quadrant 1 or 2
    end

    // One micro-rotation from the current registers
    always_comb begin
        x_sh    = x_q >>> cnt_q;
        y_sh    = y_q >>> cnt_q;
        lut_val = atan_lut(cnt_q);
        if (!z_q[DW_NOR-1]) begin
            x_it = x_q - y_sh;
            y_it = y_q + x_sh;
            z_it = z_q - lut_val;
        end else begin
            x_it = x_q + y_sh;
            y_it = y_q - x_sh;
            z_it = z_q + lut_val;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        dout_x_d = dout_x;
        dout_y_d = dout_y;

        case (state_q)
            IDLE: begin
                if (din_valid && din_ready) begin
                    // Pre-rotate by 180 deg for quadrants 1/2 so z0 stays within +-90 deg
                    if (swap_half) begin
                        x_d = -s_val;
                        z_d = {~din_angle[DW_NOR-1], din_angle[DW_NOR-2:0]};
                    end else begin
                        x_d = s_val;
                        z_d = din_angle;
                    end
                    y_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                x_d   = x_it;
                y_d   = y_it;
                z_d   = z_it;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(T_IR_NUM - 1)) begin
                    dout_x_d = DW'(x_it >>> 2);
                    dout_y_d = DW'(y_it >>> 2);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (dout_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        din_ready_d  = (state_d == IDLE);
        dout_valid_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            din_ready  <= 1'b0;
            dout_valid <= 1'b0;
            dout_x     <= '0;
            dout_y     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            din_ready  <= din_ready_d;
            dout_valid <= dout_valid_d;
            dout_x     <= dout_x_d;
            dout_y     <= dout_y_d;
        end
    end

endmodule

// File: tb/tb_cordic_rotate_iter.sv
// Testbench for cordic_rotate_iter: directed cases, backpressure, mid-operation
// reset and a randomized sweep against a floating-point polar-to-Cartesian model.
module tb_cordic_rotate_iter;

    localparam int DW     = 16;
    localparam int DW_NOR = 20;
    localparam int TOL    = 3;
    localparam int N_RAND = 1000;
    localparam real PI    = 3.14159265358979323846;

    logic                     clk;
    logic                     rst_n;
    logic                     din_valid;
    logic                     din_ready;
    logic signed [DW-1:0]     din_mag;
    logic        [DW_NOR-1:0] din_angle;
    logic                     dout_valid;
    logic                     dout_ready;
    logic signed [DW-1:0]     dout_x;
    logic signed [DW-1:0]     dout_y;

    int n_cmp = 0;
    int n_err = 0;

    cordic_rotate_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_mag    (din_mag),
        .din_angle  (din_angle),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_x     (dout_x),
        .dout_y     (dout_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        int diff;
        n_cmp++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    // Ideal polar-to-Cartesian reference
    function automatic int model_x(input int mag, input int ang);
        return rnd(real'(mag) * $cos(2.0 * PI * real'(ang) / 1048576.0));
    endfunction

    function automatic int model_y(input int mag, input int ang);
        return rnd(real'(mag) * $sin(2.0 * PI * real'(ang) / 1048576.0));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int mag, input int ang);
        int n = 0;
        while (!din_ready && n < 50) begin
            tick();
            n++;
        end
        if (!din_ready) check("ready_timeout", 0, 1, 0);
        din_valid = 1'b1;
        din_mag   = DW'(mag);
        din_angle = DW_NOR'(ang);
        tick();
        din_valid = 1'b0;
        din_mag   = DW'($urandom);
        din_angle = DW_NOR'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!dout_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_result();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("valid_fall", int'(dout_valid), 0, 0);
        check("ready_rise", int'(din_ready), 1, 0);
    endtask

    int t_mag[10] = '{10000, 10000, 10000, 10000, 10000, 10000, 10000, -8000, 16383, 0};
    int t_ang[10] = '{'h00000, 'h40000, 'h80000, 'hC0000, 'h20000, 'h60000, 'hE0000,
                      'h80000, 'h3FFFF, 'h12345};
    int t_ex[10]  = '{10000, 0, -10000, 0, 7071, -7071, 7071, 8000, 0, 0};
    int t_ey[10]  = '{0, 10000, 0, -10000, 7071, 7071, -7071, 0, 16383, 0};

    initial begin
        int lat, hx, hy;
        int q_mag[$];
        int q_ang[$];
        bit in_fire, out_fire;
        int p_mag, p_ang, p_x, p_y;
        int sent, recv, cyc;

        rst_n      = 1'b0;
        din_valid  = 1'b0;
        din_mag    = '0;
        din_angle  = '0;
        dout_ready = 1'b0;
        tick();
        tick();
        check("rst_din_ready", int'(din_ready), 0, 0);
        check("rst_dout_valid", int'(dout_valid), 0, 0);
        check("rst_dout_x", int'(dout_x), 0, 0);
        check("rst_dout_y", int'(dout_y), 0, 0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", int'(din_ready), 1, 0);

        // Directed cardinal, diagonal, negative and extreme cases
        for (int i = 0; i < 10; i++) begin
            start_op(t_mag[i], t_ang[i]);
            wait_done(lat);
            check($sformatf("lat_%0d", i), lat, 15, 0);
            check($sformatf("x_%0d", i), int'(dout_x), t_ex[i], TOL);
            check($sformatf("y_%0d", i), int'(dout_y), t_ey[i], TOL);
            release_result();
        end

        // Backpressure in DONE with a competing input offered
        start_op(5000, 'h15555);
        wait_done(lat);
        hx = int'(dout_x);
        hy = int'(dout_y);
        check("bp_x", hx, model_x(5000, 'h15555), TOL);
        check("bp_y", hy, model_y(5000, 'h15555), TOL);
        din_valid = 1'b1;
        din_mag   = DW'(-3000);
        din_angle = DW_NOR'('h90000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_x", int'(dout_x), hx, 0);
            check("bp_hold_y", int'(dout_y), hy, 0);
            check("bp_din_ready", int'(din_ready), 0, 0);
            check("bp_dout_valid", int'(dout_valid), 1, 0);
        end
        din_valid = 1'b0;
        release_result();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_no_capture", int'(dout_valid), 0, 0);
            check("bp_idle_ready", int'(din_ready), 1, 0);
        end

        // Reset at iteration 7 of an operation
        start_op(12000, 'h2AAAA);
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_valid", int'(dout_valid), 0, 0);
        check("abort_ready", int'(din_ready), 0, 0);
        check("abort_x", int'(dout_x), 0, 0);
        check("abort_y", int'(dout_y), 0, 0);
        tick();
        check("abort_ready_rise", int'(din_ready), 1, 0);
        check("abort_no_result", int'(dout_valid), 0, 0);
        start_op(-12000, 'hA5A5A);
        wait_done(lat);
        check("post_abort_lat", lat, 15, 0);
        check("post_abort_x", int'(dout_x), model_x(-12000, 'hA5A5A), TOL);
        check("post_abort_y", int'(dout_y), model_y(-12000, 'hA5A5A), TOL);
        release_result();

        // Random sweep with random valid/ready and an in-order scoreboard
        sent = 0;
        recv = 0;
        cyc = 0;
        in_fire = 1'b0;
        out_fire = 1'b0;
        p_mag = 0; p_ang = 0; p_x = 0; p_y = 0;
        while (recv < N_RAND && cyc < 60000) begin
            tick();
            cyc++;
            if (in_fire) begin
                q_mag.push_back(p_mag);
                q_ang.push_back(p_ang);
                sent++;
            end
            if (out_fire) begin
                if (q_mag.size() == 0) begin
                    check("rand_spurious", 1, 0, 0);
                end else begin
                    int m, a;
                    m = q_mag.pop_front();
                    a = q_ang.pop_front();
                    check($sformatf("rand_x m=%0d a=%0h", m, a), p_x, model_x(m, a), TOL);
                    check($sformatf("rand_y m=%0d a=%0h", m, a), p_y, model_y(m, a), TOL);
                end
                recv++;
            end
            if (sent < N_RAND && ($urandom_range(0, 3) != 0)) begin
                din_valid = 1'b1;
                din_mag   = DW'(int'($urandom_range(0, 32766)) - 16383);
                din_angle = DW_NOR'($urandom);
            end else begin
                din_valid = 1'b0;
            end
            dout_ready = 1'($urandom_range(0, 1));
            in_fire  = din_valid && din_ready;
            p_mag    = int'(din_mag);
            p_ang    = int'(din_angle);
            out_fire = dout_valid && dout_ready;
            p_x      = int'(dout_x);
            p_y      = int'(dout_y);
        end
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        check("rand_recv_count", recv, N_RAND, 0);
        check("rand_sent_count", sent, N_RAND, 0);
        check("rand_queue_empty", q_mag.size(), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
